// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock.
// Optional ALU_DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module alu_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, q, m, dvd_raw;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, dvs_zero;
  logic             accept, last;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] mag_dvd, mag_dvs;
  logic [WIDTH-1:0] q_fix, r_fix;

  // start is refused while the done pulse is still on the output
  assign accept = (state == IDLE) && start && !done;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  assign mag_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign mag_dvs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // partial remainder never exceeds the divisor, so WIDTH bits of A suffice
  assign shifted = {a, q[WIDTH-1]};
  assign diff    = shifted - {1'b0, m};

  always_comb begin
    q_fix = neg_q ? -q : q;
    r_fix = neg_r ? -a : a;
    if (dvs_zero) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_DIV_ZERO_FAST_EN
          state_nx = (divisor == '0) ? FIX : RUN;
`else
          state_nx = RUN;
`endif
        end
      end
      RUN:  if (last) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      dvd_raw   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
    end else begin
      busy <= (state_nx == RUN) || (state_nx == FIX);
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            a        <= '0;
            q        <= mag_dvd;
            m        <= mag_dvs;
            cnt      <= '0;
            dvd_raw  <= dividend;
            dvs_zero <= (divisor == '0);
            neg_q    <= is_signed &
                        (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= is_signed & dividend[WIDTH-1];
          end
        end
        RUN: begin
          if (diff[WIDTH]) begin
            a <= shifted[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end else begin
            a <= diff[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          div_zero  <= dvs_zero;
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq (WIDTH=32).
// Zero-divisor latency expectation follows ALU_DIV_ZERO_FAST_EN.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int bsy;
  int pulses;

`ifdef ALU_DIV_ZERO_FAST_EN
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_ZERO = 34;
`endif

  always #5 clk = ~clk;

  alu_div_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // lat = cycles from accepting edge to done seen (-1 timeout,
  // -2 aborted by reset); bn = cycles busy was seen high
  task automatic run(input logic [31:0] dvd, input logic [31:0] dvs,
                     input logic sgn, input int inj, input int rst_at,
                     output int lt, output int bn);
    lt = -1;
    bn = 0;
    start = 1'b1;
    dividend = dvd;
    divisor = dvs;
    is_signed = sgn;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) bn++;
    for (int c = 1; c <= 100; c++) begin
      if (c == inj) begin
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        is_signed = 1'b0;
      end else begin
        dividend = 32'hDEAD_BEEF;
        divisor = 32'h1;
      end
      if (c == rst_at) reset = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == rst_at) begin
        reset = 1'b0;
        lt = -2;
        break;
      end
      if (busy) bn++;
      if (done) begin
        lt = c;
        break;
      end
    end
  endtask

  task automatic res(input string tag, input logic [31:0] eq,
                     input logic [31:0] er, input logic ez);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    res("reset", 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(32'd100, 32'd7, 1'b0, 0, 0, lat, bsy);
    check("u100/7 latency", lat, 32'd34);
    check("u100/7 busy cycles", bsy, 32'd33);
    res("u100/7", 32'd14, 32'd2, 1'b0);
    @(posedge clk);
    #1;
    check("u100/7 done pulse", {31'd0, done}, 32'd0);

    run(-32'sd7, 32'd2, 1'b1, 0, 0, lat, bsy);
    check("s-7/2 latency", lat, 32'd34);
    res("s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #1;

    run(32'd7, -32'sd2, 1'b1, 0, 0, lat, bsy);
    res("s7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    @(posedge clk);
    #1;

    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, lat, bsy);
    res("sMIN/-1", 32'h8000_0000, 32'd0, 1'b0);
    @(posedge clk);
    #1;

    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, lat, bsy);
    res("uMIN/-1", 32'd0, 32'h8000_0000, 1'b0);
    @(posedge clk);
    #1;

    run(32'd5, 32'd0, 1'b0, 0, 0, lat, bsy);
    check("u5/0 latency", lat, LAT_ZERO);
    res("u5/0", 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(posedge clk);
    #1;

    run(32'd5, 32'd0, 1'b1, 0, 0, lat, bsy);
    check("s5/0 latency", lat, LAT_ZERO);
    res("s5/0", 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(posedge clk);
    #1;

    run(32'd100, 32'd7, 1'b0, 10, 0, lat, bsy);
    check("inject latency", lat, 32'd34);
    res("inject", 32'd14, 32'd2, 1'b0);

    // start while done is high must be dropped
    start = 1'b1;
    dividend = 32'd55;
    divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done-cycle start busy", {31'd0, busy}, 32'd0);
    check("done-cycle start done", {31'd0, done}, 32'd0);

    run(32'd1000, 32'd3, 1'b0, 0, 0, lat, bsy);
    check("next latency", lat, 32'd34);
    res("next", 32'd333, 32'd1, 1'b0);
    @(posedge clk);
    #1;

    run(32'd100, 32'd7, 1'b0, 0, 15, lat, bsy);
    check("abort status", lat, -32'sd2);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    res("abort", 32'd0, 32'd0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort no done", pulses, 32'd0);

    run(32'd100, 32'd7, 1'b0, 0, 0, lat, bsy);
    check("post-abort latency", lat, 32'd34);
    res("post-abort", 32'd14, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle, parametrised restoring divider for the CPU datapath's DIV/DIVU instructions.
- Successor to the combinational divider: one restoring iteration per clock instead of a WIDTH-deep combinational chain.
- Adds signed/unsigned mode, a start/done handshake, and divide-by-zero reporting.
- Sits beside the ALU; the control unit stalls on `busy` and writes `quotient`/`remainder` to LO/HI on `done`.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start
- dividend  in  WIDTH  sampled with start
- divisor  in  WIDTH  sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse; results valid from this cycle
- quotient  out  WIDTH  registered result; held until next accepted start
- remainder  out  WIDTH  registered result; held until next accepted start
- div_zero  out  1  registered; set with done when divisor was 0; held like results

Behaviour:
- Reset (synchronous, active-high):
  - State → IDLE; busy, done, div_zero, quotient, remainder → 0; counter → 0.
  - Reset asserted mid-operation aborts immediately; no done pulse.
- States: IDLE → RUN → FIX → DONE → IDLE.
- IDLE:
  - On start=1, latch operands and mode.
  - Load magnitudes: |dividend| and |divisor| when is_signed=1 and the operand MSB is 1, else the raw values.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both signed mode only.
  - A = 0 (WIDTH+1 bits), Q = |dividend|, counter = 0 → RUN; busy=1 next cycle.
- RUN, one iteration per cycle:
  - {A,Q} shifted left 1; A = A − M.
  - If A is negative (MSB), restore A = A + M and set Q[0]=0; else Q[0]=1.
  - counter+1; after the WIDTH-th iteration → FIX.
- FIX:
  - quotient = neg_q ? −Q : Q; remainder = neg_r ? −A[WIDTH-1:0] : A[WIDTH-1:0].
  - Divisor == 0 override: quotient = all ones, remainder = original dividend, div_zero=1.
  - → DONE.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Latency: start sampled at edge 0; done high in the cycle following edge WIDTH+2 (34 cycles for WIDTH=32).
- start while busy or in DONE is ignored (no queueing). start in the same cycle done is high is ignored; the first accept is the following cycle.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / −1 yields quotient = MIN, remainder = 0, no flag (WIDTH-bit wrap).
- Operands may change after acceptance without effect.
- Outputs are never combinational from inputs.

Optional Feature:
- Macro: ALU_DIV_ZERO_FAST_EN.
- Defined: when the latched divisor is 0, IDLE goes directly to FIX, skipping RUN. done arrives at latency 2 (high after edge 2). Results and div_zero are as above.
- Undefined: divide-by-zero takes the full WIDTH+2 latency; result values are identical.

Test Plan (WIDTH=32):
- Unsigned 100 / 7, is_signed=0 → done exactly 34 cycles after start; quotient=14, remainder=2, div_zero=0; busy high for 33 cycles.
- Signed −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_zero=0. The same operands unsigned → quotient=0, remainder=0x80000000.
- 5 / 0, either mode → quotient=0xFFFFFFFF, remainder=5, div_zero=1:
  - done at cycle 34 without the macro;
  - done at cycle 2 with ALU_DIV_ZERO_FAST_EN.
- Pulse start again at cycle 10 of a running divide with new operands → ignored; first results unchanged and done at 34. Start the next divide on the cycle after done → accepted.
- Assert reset at cycle 15 of a divide → next cycle busy=0, quotient=remainder=0, no done pulse. A fresh 100 / 7 then completes normally.
